// File: rtl/pdp8_pkg.sv
// Shared PDP-8 datapath types: FSM states, rotate op codes, AC width.
// Imported by the operate-group blocks.
package pdp8_pkg;

  localparam int AC_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    DONE
  } state_t;

  typedef logic [1:0] op_t;

  localparam op_t OP_NOP = 2'd0;
  localparam op_t OP_RL  = 2'd1;
  localparam op_t OP_RR  = 2'd2;
  localparam op_t OP_BSW = 2'd3;

  function automatic op_t decode_op(
    input logic left,
    input logic right,
    input logic twice
  );
    op_t op;
    op = OP_NOP;
    unique case (1'b1)
      (left & ~right):          op = OP_RL;
      (right & ~left):          op = OP_RR;
      (~left & ~right & twice): op = OP_BSW;
      default:                  op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rotater_rise_detect.sv
// Registered rising-edge detector with synchronous active-low clear.
// rise is high in the cycle where d is high and was low last cycle.
module rise_detect (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic rise
);

  logic last_q;
  logic last_d;

  always_comb begin
    last_d = d;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end

  assign rise = d & ~last_q;

endmodule

// File: rtl/rotater.sv
// Operate-group rotate stage: RAL/RAR/RTL/RTR/BSW on {L,AC},
// one bit position per clock, finishing with a done/L_force pulse.
module rotater
  import pdp8_pkg::*;
#(
  parameter int WIDTH = AC_W
) (
  input  logic             clk,
  input  logic             CLEAR_n,
  input  logic             ROT_ck,
  input  logic             ROT_left,
  input  logic             ROT_right,
  input  logic             ROT_twice,
  input  logic [WIDTH-1:0] AC_in,
  input  logic             L_in,
  output logic [WIDTH-1:0] AC_out,
  output logic             L_out,
  output logic             L_force,
  output logic             busy,
  output logic             done
);

  localparam int H = WIDTH / 2;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH:0]   w_q, w_d;
  logic [WIDTH:0]   w_step;
  logic [WIDTH-1:0] ac_out_q, ac_out_d;
  logic             l_out_q, l_out_d;
  logic             l_force_q, l_force_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ck_rise;
  logic             start;
  op_t              dec_op;

  rise_detect u_rise (
    .clk   (clk),
    .clr_n (CLEAR_n),
    .d     (ROT_ck),
    .rise  (ck_rise)
  );

  assign start  = ck_rise & (state_q == IDLE);
  assign dec_op = decode_op(ROT_left, ROT_right, ROT_twice);

  always_comb begin
    w_step = w_q;
    unique case (op_q)
      OP_RL:   w_step = {w_q[WIDTH-1:0], w_q[WIDTH]};
      OP_RR:   w_step = {w_q[0], w_q[WIDTH:1]};
      OP_BSW:  w_step = {w_q[WIDTH], w_q[H-1:0], w_q[WIDTH-1:H]};
      default: w_step = w_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    w_d       = w_q;
    ac_out_d  = ac_out_q;
    l_out_d   = l_out_q;
    l_force_d = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          w_d    = {L_in, AC_in};
          op_d   = dec_op;
          busy_d = 1'b1;
          state_d = STEP;
          if ((dec_op == OP_RL) || (dec_op == OP_RR)) begin
            cnt_d = ROT_twice ? 2'd2 : 2'd1;
          end else begin
            cnt_d = 2'd0;
          end
        end
      end
      STEP: begin
        w_d = w_step;
        // Last step publishes the result on the same edge, so RAL is 2 edges.
        if (cnt_q > 2'd1) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          cnt_d     = 2'd0;
          ac_out_d  = w_step[WIDTH-1:0];
          l_out_d   = w_step[WIDTH];
          done_d    = 1'b1;
          l_force_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!CLEAR_n) begin
      state_q   <= IDLE;
      op_q      <= OP_NOP;
      cnt_q     <= 2'd0;
      w_q       <= '0;
      ac_out_q  <= '0;
      l_out_q   <= 1'b0;
      l_force_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      w_q       <= w_d;
      ac_out_q  <= ac_out_d;
      l_out_q   <= l_out_d;
      l_force_q <= l_force_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign AC_out  = ac_out_q;
  assign L_out   = l_out_q;
  assign L_force = l_force_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_rotater.sv
// Directed-vector bench for rotater: op table plus edge-hold and
// mid-operation reset sequences.
module tb_rotater;

  logic        clk;
  logic        CLEAR_n;
  logic        ROT_ck;
  logic        ROT_left;
  logic        ROT_right;
  logic        ROT_twice;
  logic [11:0] AC_in;
  logic        L_in;
  logic [11:0] AC_out;
  logic        L_out;
  logic        L_force;
  logic        busy;
  logic        done;

  int errors;
  int checks;
  int done_cnt;
  int lf_cnt;

  rotater #(.WIDTH(12)) dut (
    .clk       (clk),
    .CLEAR_n   (CLEAR_n),
    .ROT_ck    (ROT_ck),
    .ROT_left  (ROT_left),
    .ROT_right (ROT_right),
    .ROT_twice (ROT_twice),
    .AC_in     (AC_in),
    .L_in      (L_in),
    .AC_out    (AC_out),
    .L_out     (L_out),
    .L_force   (L_force),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (L_force) lf_cnt <= lf_cnt + 1;
  end

  typedef struct {
    string       name;
    logic        left;
    logic        right;
    logic        twice;
    logic [11:0] ac;
    logic        l;
    logic [11:0] exp_ac;
    logic        exp_l;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input bit hold);
    int edges;
    @(negedge clk);
    ROT_left  = v.left;
    ROT_right = v.right;
    ROT_twice = v.twice;
    AC_in     = v.ac;
    L_in      = v.l;
    ROT_ck    = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    AC_in = ~v.ac;
    L_in  = ~v.l;
    while (!done && edges < 8) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk({v.name, " latency"}, edges, v.exp_lat);
    chk({v.name, " AC_out"}, AC_out, v.exp_ac);
    chk({v.name, " L_out"}, L_out, v.exp_l);
    chk({v.name, " L_force"}, L_force, 1'b1);
    @(negedge clk);
    chk({v.name, " done drop"}, done, 1'b0);
    chk({v.name, " L_force drop"}, L_force, 1'b0);
    chk({v.name, " busy drop"}, busy, 1'b0);
    if (!hold) ROT_ck = 1'b0;
  endtask

  vec_t vecs[10];
  vec_t v;
  int   base;
  int   lbase;

  initial begin
    errors    = 0;
    checks    = 0;
    done_cnt  = 0;
    lf_cnt    = 0;
    CLEAR_n   = 1'b0;
    ROT_ck    = 1'b0;
    ROT_left  = 1'b0;
    ROT_right = 1'b0;
    ROT_twice = 1'b0;
    AC_in     = '0;
    L_in      = 1'b0;

    vecs[0] = '{"RAL", 1, 0, 0, 12'o4000, 0, 12'o0000, 1, 2};
    vecs[1] = '{"RAR", 0, 1, 0, 12'o0001, 0, 12'o0000, 1, 2};
    vecs[2] = '{"RTR", 0, 1, 1, 12'o0001, 0, 12'o4000, 0, 3};
    vecs[3] = '{"RTL", 1, 0, 1, 12'o0000, 1, 12'o0002, 0, 3};
    vecs[4] = '{"BSW", 0, 0, 1, 12'o1234, 1, 12'o3412, 1, 2};
    vecs[5] = '{"NOP", 0, 0, 0, 12'o5252, 1, 12'o5252, 1, 2};
    vecs[6] = '{"ILL", 1, 1, 0, 12'o7777, 0, 12'o7777, 0, 2};
    vecs[7] = '{"RAL2", 1, 0, 0, 12'o2525, 1, 12'o5253, 0, 2};
    vecs[8] = '{"RAR2", 0, 1, 0, 12'o5252, 1, 12'o6525, 0, 2};
    vecs[9] = '{"ILL2", 1, 1, 1, 12'o1234, 1, 12'o1234, 1, 2};

    repeat (3) @(posedge clk);
    @(negedge clk);
    CLEAR_n = 1'b1;
    chk("reset AC_out", AC_out, 12'o0);
    chk("reset L_out", L_out, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset L_force", L_force, 1'b0);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i], 1'b0);
    end

    // ROT_ck held high: one op only, then a busy-time edge is ignored.
    v = '{"HOLD", 1, 0, 1, 12'o0001, 0, 12'o0004, 0, 3};
    base = done_cnt;
    run_op(v, 1'b1);
    repeat (6) @(negedge clk);
    chk("hold no repeat", done_cnt - base, 1);
    ROT_ck = 1'b0;
    @(negedge clk);
    base = done_cnt;
    ROT_ck    = 1'b1;
    ROT_left  = 1'b1;
    ROT_right = 1'b0;
    ROT_twice = 1'b1;
    AC_in     = 12'o0010;
    L_in      = 1'b0;
    @(negedge clk);
    ROT_ck = 1'b0;
    @(negedge clk);
    ROT_ck = 1'b1;
    repeat (10) @(negedge clk);
    chk("busy edge single done", done_cnt - base, 1);
    chk("busy edge AC_out", AC_out, 12'o0040);
    ROT_ck = 1'b0;
    @(negedge clk);

    // Reset during the STEP cycle of an RTL.
    base  = done_cnt;
    lbase = lf_cnt;
    ROT_left  = 1'b1;
    ROT_right = 1'b0;
    ROT_twice = 1'b1;
    AC_in     = 12'o7777;
    L_in      = 1'b1;
    ROT_ck    = 1'b1;
    @(negedge clk);
    chk("abort busy set", busy, 1'b1);
    CLEAR_n = 1'b0;
    @(negedge clk);
    chk("abort busy", busy, 1'b0);
    chk("abort AC_out", AC_out, 12'o0);
    chk("abort L_out", L_out, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort L_force", L_force, 1'b0);
    CLEAR_n = 1'b1;
    ROT_ck  = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort no done", done_cnt - base, 0);
    chk("abort no L_force", lf_cnt - lbase, 0);
    run_op(vecs[0], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
